cpuc_mem_mover: RTL and testbench
=================================

// Module: cpuc_mem_mover
// PURPOSE
//  Initiator-side engine that drives one port of the CPUC dual-port RAM (address/wren/data out, q in).
//  Executes COPY (src->dst block move) and FILL (constant pattern) commands accepted over a valid/ready
//  command handshake, freeing the core from word-by-word memory loops. Other RAM port stays with the core.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width; must equal the RAM's ADDR_WIDTH (tie to cpuc_package at instance)
//  DATA_WIDTH  32  word width; must equal the RAM's DATA_WIDTH
// PORTS
//  clk          in   1             system clock (the only clock)
//  rst_n        in   1             asynchronous, active-low reset
//  cmd_valid    in   1             command present
//  cmd_ready    out  1             engine idle, command accepted when cmd_valid&cmd_ready
//  cmd_op       in   1             0=COPY, 1=FILL
//  cmd_src      in   ADDR_WIDTH    COPY source start address (ignored for FILL)
//  cmd_dst      in   ADDR_WIDTH    destination start address
//  cmd_len      in   ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH
//  cmd_pattern  in   DATA_WIDTH    FILL data (ignored for COPY)
//  abort        in   1             stop current command
//  busy         out  1             command in progress
//  done         out  1             one-cycle pulse at command end
//  aborted      out  1             valid with done: command ended by abort
//  words_done   out  ADDR_WIDTH+1  words written by current/last command
//  mem_address  out  ADDR_WIDTH    to RAM address port
//  mem_wren     out  1             to RAM wren port
//  mem_data     out  DATA_WIDTH    to RAM data port
//  mem_q        in   DATA_WIDTH    from RAM q (combinational read of mem[mem_address])
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1, busy=0, done=0, aborted=0, words_done=0, mem_address=0, mem_wren=0,
//   mem_data=0. Reset mid-command abandons it: no further writes, no done pulse.
//  All outputs registered except cmd_ready (=state==IDLE) and mem_* (decoded from state/pointers).
//  States: IDLE, RD, WR, FILL, FIN.
//   IDLE: accept on cmd_valid -> latch fields, clear words_done/aborted; len==0 -> FIN; FILL -> FILL; COPY -> RD.
//   RD  : mem_address=src_ptr, mem_wren=0; capture mem_q into data reg at clock edge -> WR.
//   WR  : mem_address=dst_ptr, mem_wren=1, mem_data=data reg; step pointers, words_done+1;
//         last word -> FIN else -> RD. COPY = 2 cycles/word.
//   FILL: mem_address=dst_ptr, mem_wren=1, mem_data=pattern; step, count; last -> FIN. 1 cycle/word.
//   FIN : done=1 for this cycle, busy=0 next -> IDLE. New command accepted no earlier than next cycle.
//  busy=1 from the cycle after acceptance through FIN inclusive.
//  Latency: accept at edge T -> first RAM access cycle T+1; done high in cycle after final write.
//  Direction: COPY with dst>src and dst<src+len (unwrapped, ADDR_WIDTH+1 arithmetic) runs descending from
//   src+len-1/dst+len-1 so overlap copies are exact memmove; all other cases ascending. FILL always ascending.
//  Pointers wrap modulo 2**ADDR_WIDTH; len==2**ADDR_WIDTH covers whole memory once.
//  abort sampled in RD/WR/FILL: that cycle's write is suppressed (mem_wren=0), -> FIN with aborted=1.
//   abort in IDLE/FIN ignored. abort and final write same cycle: abort wins, words_done excludes that word.
//  cmd_* fields only sampled at acceptance; changes while busy have no effect.
//  Core-side port writing same address same cycle: RAM port ordering resolves, engine does not arbitrate.
// TESTING
//  FILL dst=0x010 len=4 pattern=0xA5A5_0001 -> mem[0x10..0x13]=pattern, 4 wren cycles, done at T+5, words_done=4.
//  COPY src=0x000 dst=0x100 len=3 (mem[0..2]=1,2,3) -> mem[0x100..0x102]=1,2,3, done at T+7, sources intact.
//  COPY overlap src=0x020 dst=0x021 len=4 (mem=10,11,12,13) -> descending; mem[0x21..0x24]=10,11,12,13.
//  FILL dst=2**ADDR_WIDTH-2 len=4 -> writes last two words then 0x000,0x001; len=0 -> done at T+1, no wren.
//  FILL len=8, abort on 3rd write cycle -> 2 words written, done&aborted=1, words_done=2, cmd_ready next cycle.
//  rst_n low mid-COPY -> all outputs at reset values immediately, no done; next command runs normally.

Source files
------------

// File: rtl/cpuc_mem_mover.sv
// cpuc_mem_mover: block COPY / FILL engine driving one port of the CPUC dual-port RAM.
// Commands arrive over a valid/ready handshake. COPY moves a word in two cycles (read, then write).
// FILL writes one word per cycle. An overlapping COPY into a higher address runs descending,
// so the result matches memmove.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid / cmd_ready            command handshake (ready == engine idle, combinational)
//   cmd_op, cmd_src, cmd_dst,        command fields, sampled only at acceptance
//   cmd_len, cmd_pattern
//   abort                            terminate the running command, suppressing that cycle's write
//   busy, done, aborted, words_done  registered status
//   mem_address, mem_wren, mem_data  RAM port drive, decoded from state/pointers
//   mem_q                            RAM read data for mem[mem_address]
module cpuc_mem_mover #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0] cmd_pattern,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned LW = ADDR_WIDTH + 1;
  localparam int unsigned DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   src_q, src_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   pattern_q, pattern_d;
  logic [DW-1:0]   data_q, data_d;
  logic            desc_q, desc_d;
  logic [LW-1:0]   words_done_q, words_done_d;
  logic            aborted_q, aborted_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Overlap detection uses unwrapped arithmetic so src+len never aliases to a low address.
  logic [LW-1:0]   src_ext, dst_ext, src_end;
  logic            cmd_desc;
  logic [AW-1:0]   src_start, dst_start;

  always_comb begin
    src_ext   = {1'b0, cmd_src};
    dst_ext   = {1'b0, cmd_dst};
    src_end   = src_ext + cmd_len;
    cmd_desc  = !cmd_op && (dst_ext > src_ext) && (dst_ext < src_end);
    src_start = cmd_desc ? AW'(src_ext + cmd_len - LW'(1)) : cmd_src;
    dst_start = cmd_desc ? AW'(dst_ext + cmd_len - LW'(1)) : cmd_dst;
  end

  // Next state, datapath updates and RAM port decode.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    pattern_d    = pattern_q;
    data_d       = data_q;
    desc_d       = desc_q;
    words_done_d = words_done_q;
    aborted_d    = aborted_q;
    mem_address  = '0;
    mem_wren     = 1'b0;
    mem_data     = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          src_d        = src_start;
          dst_d        = dst_start;
          rem_d        = cmd_len;
          pattern_d    = cmd_pattern;
          desc_d       = cmd_desc;
          words_done_d = '0;
          aborted_d    = 1'b0;
          if (cmd_len == '0)  state_d = S_FIN;
          else if (cmd_op)    state_d = S_FILL;
          else                state_d = S_RD;
        end
      end

      S_RD: begin
        mem_address = src_q;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          data_d  = mem_q;
          state_d = S_WR;
        end
      end

      S_WR, S_FILL: begin
        mem_address = dst_q;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          mem_wren     = 1'b1;
          mem_data     = (state_q == S_FILL) ? pattern_q : data_q;
          src_d        = desc_q ? (src_q - AW'(1)) : (src_q + AW'(1));
          dst_d        = desc_q ? (dst_q - AW'(1)) : (dst_q + AW'(1));
          rem_d        = rem_q - LW'(1);
          words_done_d = words_done_q + LW'(1);
          if (rem_q == LW'(1))        state_d = S_FIN;
          else if (state_q == S_WR)   state_d = S_RD;
          else                        state_d = S_FILL;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      pattern_q    <= '0;
      data_q       <= '0;
      desc_q       <= 1'b0;
      words_done_q <= '0;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      pattern_q    <= pattern_d;
      data_q       <= data_d;
      desc_q       <= desc_d;
      words_done_q <= words_done_d;
      aborted_q    <= aborted_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_cpuc_mem_mover.sv
// Directed bench for cpuc_mem_mover with a behavioural RAM port model.
module tb_cpuc_mem_mover;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 11;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_pattern;
  logic          abort, busy, done, aborted;
  logic [LW-1:0] words_done;
  logic [AW-1:0] mem_address;
  logic          mem_wren;
  logic [DW-1:0] mem_data, mem_q;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpuc_mem_mover #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
    .mem_address(mem_address), .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
  );

  // RAM port model: combinational read, write at clock edge; backdoor preload only while idle.
  assign mem_q = mem[mem_address];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wren) mem[mem_address] <= mem_data;
  end

  // Entered and left at posedge+1.
  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // Issue a command and follow it to done. k counts cycles after the accepting edge (k=1 first access cycle).
  task automatic run_cmd(input logic op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [LW-1:0] len, input logic [DW-1:0] pat, input int abort_k,
                         output int done_k, output int wr_cnt, output logic [LW-1:0] wd,
                         output logic ab, output logic busy1, output logic rdy_after);
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_src = ~src; cmd_dst = ~dst; cmd_len = LW'(5); cmd_pattern = ~pat;
    done_k = -1; wr_cnt = 0; wd = '0; ab = 1'b0; busy1 = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      abort = (k == abort_k);
      #1;
      if (k == 1) busy1 = busy;
      if (mem_wren === 1'b1) wr_cnt++;
      if (done === 1'b1) begin
        done_k = k; wd = words_done; ab = aborted;
        break;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    checks++;
    if (done_k < 0) begin
      errors++;
      $display("FAIL cmd_timeout: no done within %0d cycles", BUDGET);
    end
    @(posedge clk); #1;
    rdy_after = cmd_ready & ~busy & ~done;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (cmd_ready !== 1'b1)  begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (aborted !== 1'b0)    begin errors++; $display("FAIL rst_aborted: got %b want 0", aborted); end
    checks++; if (words_done !== '0)   begin errors++; $display("FAIL rst_words_done: got %0d want 0", words_done); end
    checks++; if (mem_address !== '0)  begin errors++; $display("FAIL rst_mem_address: got %h want 0", mem_address); end
    checks++; if (mem_wren !== 1'b0)   begin errors++; $display("FAIL rst_mem_wren: got %b want 0", mem_wren); end
    checks++; if (mem_data !== '0)     begin errors++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
  endtask

  task automatic test_fill_basic;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    poke(AW'(12'h00F), 32'h5E5E_000F);
    poke(AW'(12'h014), 32'h5E5E_0014);
    run_cmd(1'b1, AW'(0), AW'(12'h010), LW'(4), 32'hA5A5_0001, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 5)      begin errors++; $display("FAIL fill_done_cycle: got %0d want 5", dk); end
    checks++; if (wc !== 4)      begin errors++; $display("FAIL fill_wren_cycles: got %0d want 4", wc); end
    checks++; if (wd !== LW'(4)) begin errors++; $display("FAIL fill_words_done: got %0d want 4", wd); end
    checks++; if (ab !== 1'b0)   begin errors++; $display("FAIL fill_aborted: got %b want 0", ab); end
    checks++; if (b1 !== 1'b1)   begin errors++; $display("FAIL fill_busy_first: got %b want 1", b1); end
    checks++; if (ra !== 1'b1)   begin errors++; $display("FAIL fill_ready_after: got %b want 1", ra); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[AW'(16 + i)] !== 32'hA5A5_0001) begin
        errors++; $display("FAIL fill_mem[%0d]: got %h want a5a50001", 16 + i, mem[AW'(16 + i)]);
      end
    end
    checks++; if (mem[AW'(15)] !== 32'h5E5E_000F) begin errors++; $display("FAIL fill_below: got %h want 5e5e000f", mem[AW'(15)]); end
    checks++; if (mem[AW'(20)] !== 32'h5E5E_0014) begin errors++; $display("FAIL fill_above: got %h want 5e5e0014", mem[AW'(20)]); end
  endtask

  task automatic test_copy_basic;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    for (int i = 0; i < 3; i++) poke(AW'(i), DW'(i + 1));
    poke(AW'(12'h103), 32'h5E5E_0103);
    run_cmd(1'b0, AW'(0), AW'(12'h100), LW'(3), 32'hFFFF_FFFF, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 7)      begin errors++; $display("FAIL copy_done_cycle: got %0d want 7", dk); end
    checks++; if (wc !== 3)      begin errors++; $display("FAIL copy_wren_cycles: got %0d want 3", wc); end
    checks++; if (wd !== LW'(3)) begin errors++; $display("FAIL copy_words_done: got %0d want 3", wd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[AW'(256 + i)] !== DW'(i + 1)) begin errors++; $display("FAIL copy_dst[%0d]: got %h want %h", i, mem[AW'(256 + i)], DW'(i + 1)); end
      checks++;
      if (mem[AW'(i)] !== DW'(i + 1)) begin errors++; $display("FAIL copy_src[%0d]: got %h want %h", i, mem[AW'(i)], DW'(i + 1)); end
    end
    checks++; if (mem[AW'(12'h103)] !== 32'h5E5E_0103) begin errors++; $display("FAIL copy_past_end: got %h want 5e5e0103", mem[AW'(12'h103)]); end
  endtask

  task automatic test_copy_overlap;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    // Upward overlap must run descending.
    for (int i = 0; i < 4; i++) poke(AW'(32 + i), DW'(10 + i));
    poke(AW'(36), 32'h5E5E_0024);
    run_cmd(1'b0, AW'(12'h020), AW'(12'h021), LW'(4), '0, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 9) begin errors++; $display("FAIL ovl_up_done_cycle: got %0d want 9", dk); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[AW'(33 + i)] !== DW'(10 + i)) begin errors++; $display("FAIL ovl_up[%0d]: got %0d want %0d", 33 + i, mem[AW'(33 + i)], 10 + i); end
    end
    checks++; if (mem[AW'(32)] !== DW'(10)) begin errors++; $display("FAIL ovl_up_src0: got %0d want 10", mem[AW'(32)]); end
    // Downward overlap must run ascending.
    for (int i = 0; i < 3; i++) poke(AW'(65 + i), DW'(21 + i));
    run_cmd(1'b0, AW'(12'h041), AW'(12'h040), LW'(3), '0, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 7) begin errors++; $display("FAIL ovl_dn_done_cycle: got %0d want 7", dk); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[AW'(64 + i)] !== DW'(21 + i)) begin errors++; $display("FAIL ovl_dn[%0d]: got %0d want %0d", 64 + i, mem[AW'(64 + i)], 21 + i); end
    end
  endtask

  task automatic test_fill_wrap_and_zero;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = AW'(1022); exp_a[1] = AW'(1023); exp_a[2] = AW'(0); exp_a[3] = AW'(1);
    poke(AW'(2), 32'h5E5E_0002);
    poke(AW'(1021), 32'h5E5E_03FD);
    run_cmd(1'b1, AW'(0), AW'(1022), LW'(4), 32'h5555_AAAA, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 5) begin errors++; $display("FAIL wrap_done_cycle: got %0d want 5", dk); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[exp_a[i]] !== 32'h5555_AAAA) begin errors++; $display("FAIL wrap_mem[%0d]: got %h want 5555aaaa", exp_a[i], mem[exp_a[i]]); end
    end
    checks++; if (mem[AW'(2)] !== 32'h5E5E_0002)    begin errors++; $display("FAIL wrap_after: got %h want 5e5e0002", mem[AW'(2)]); end
    checks++; if (mem[AW'(1021)] !== 32'h5E5E_03FD) begin errors++; $display("FAIL wrap_before: got %h want 5e5e03fd", mem[AW'(1021)]); end
    // Zero-length command finishes immediately without touching memory.
    run_cmd(1'b1, AW'(0), AW'(2), LW'(0), 32'h1234_5678, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 1)      begin errors++; $display("FAIL len0_done_cycle: got %0d want 1", dk); end
    checks++; if (wc !== 0)      begin errors++; $display("FAIL len0_wren: got %0d want 0", wc); end
    checks++; if (wd !== LW'(0)) begin errors++; $display("FAIL len0_words_done: got %0d want 0", wd); end
    checks++; if (b1 !== 1'b1)   begin errors++; $display("FAIL len0_busy: got %b want 1", b1); end
    checks++; if (mem[AW'(2)] !== 32'h5E5E_0002) begin errors++; $display("FAIL len0_mem: got %h want 5e5e0002", mem[AW'(2)]); end
  endtask

  task automatic test_abort;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    poke(AW'(12'h082), 32'h5E5E_0082);
    run_cmd(1'b1, AW'(0), AW'(12'h080), LW'(8), 32'hC0DE_0008, 3, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 4)      begin errors++; $display("FAIL abort_done_cycle: got %0d want 4", dk); end
    checks++; if (wc !== 2)      begin errors++; $display("FAIL abort_wren: got %0d want 2", wc); end
    checks++; if (wd !== LW'(2)) begin errors++; $display("FAIL abort_words_done: got %0d want 2", wd); end
    checks++; if (ab !== 1'b1)   begin errors++; $display("FAIL abort_flag: got %b want 1", ab); end
    checks++; if (ra !== 1'b1)   begin errors++; $display("FAIL abort_ready_after: got %b want 1", ra); end
    checks++; if (mem[AW'(12'h081)] !== 32'hC0DE_0008) begin errors++; $display("FAIL abort_mem1: got %h want c0de0008", mem[AW'(12'h081)]); end
    checks++; if (mem[AW'(12'h082)] !== 32'h5E5E_0082) begin errors++; $display("FAIL abort_mem2: got %h want 5e5e0082", mem[AW'(12'h082)]); end
    // Back-to-back: the next command issued right after clears aborted.
    run_cmd(1'b1, AW'(0), AW'(12'h090), LW'(1), 32'h0000_0090, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 2)    begin errors++; $display("FAIL b2b_done_cycle: got %0d want 2", dk); end
    checks++; if (ab !== 1'b0) begin errors++; $display("FAIL b2b_aborted: got %b want 0", ab); end
    checks++; if (mem[AW'(12'h090)] !== 32'h0000_0090) begin errors++; $display("FAIL b2b_mem: got %h want 00000090", mem[AW'(12'h090)]); end
  endtask

  task automatic test_reset_mid;
    int dk, wc; logic [LW-1:0] wd; logic ab, b1, ra;
    int seen_done;
    for (int i = 0; i < 4; i++) begin
      poke(AW'(512 + i), DW'(512 + i));
      poke(AW'(768 + i), 32'h5E5E_0000 + DW'(i));
    end
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src = AW'(512); cmd_dst = AW'(768); cmd_len = LW'(8); cmd_pattern = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready: got %b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (words_done !== '0)  begin errors++; $display("FAIL rmid_words_done: got %0d want 0", words_done); end
    checks++; if (mem_wren !== 1'b0)  begin errors++; $display("FAIL rmid_wren: got %b want 0", mem_wren); end
    checks++; if (mem_address !== '0) begin errors++; $display("FAIL rmid_address: got %h want 0", mem_address); end
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d done cycles want 0", seen_done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem[AW'(768)] !== DW'(512)) begin errors++; $display("FAIL rmid_first_word: got %h want 200", mem[AW'(768)]); end
    checks++; if (mem[AW'(769)] !== 32'h5E5E_0001) begin errors++; $display("FAIL rmid_no_more_writes: got %h want 5e5e0001", mem[AW'(769)]); end
    run_cmd(1'b1, AW'(0), AW'(769), LW'(2), 32'hBEEF_0301, 0, dk, wc, wd, ab, b1, ra);
    checks++; if (dk !== 3)      begin errors++; $display("FAIL rmid_next_done: got %0d want 3", dk); end
    checks++; if (wd !== LW'(2)) begin errors++; $display("FAIL rmid_next_words: got %0d want 2", wd); end
    checks++; if (mem[AW'(770)] !== 32'hBEEF_0301) begin errors++; $display("FAIL rmid_next_mem: got %h want beef0301", mem[AW'(770)]); end
    checks++; if (mem[AW'(771)] !== 32'h5E5E_0003) begin errors++; $display("FAIL rmid_next_past: got %h want 5e5e0003", mem[AW'(771)]); end
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_pattern = '0; abort = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_fill_basic();
    test_copy_basic();
    test_copy_overlap();
    test_fill_wrap_and_zero();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
